lmc_inp_port: RTL

- Operator input peripheral for the LMC CPU; the input-side counterpart of the CPU's `out` LED path.
- When the CPU executes INP and raises `inp_req`, the block waits for a debounced press of a board push button.
- On that press it captures the slide-switch value, clamps it to 0..999, and offers it to the CPU over a valid/ready handshake.
- Sits in the top level between SW/KEY and the `cpu` instance.

---
 rtl/lmc_pkg.sv | 22 ++
 rtl/lmc_debounce.sv | 43 ++++
 rtl/lmc_inp_port.sv | 84 ++++++++
 3 files changed

// File: rtl/lmc_pkg.sv
// rtl/lmc_pkg.sv - shared LMC word constants, INP handshake states and word helpers
package lmc_pkg;

   localparam int LMC_MAX_VALUE = 999;
   localparam int LMC_WORD_W    = 11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      OFFER = 2'd2
   } inp_state_t;

   // Unsigned saturation; callers zero-extend so the compare stays unsigned.
   function automatic logic [31:0] lmc_clamp(input logic [31:0] value, input logic [31:0] max_value);
      return (value > max_value) ? max_value : value;
   endfunction

   function automatic logic [11:0] lmc_to_bcd(input logic [9:0] value);
      return {4'(value / 10'd100), 4'((value / 10'd10) % 10'd10), 4'(value % 10'd10)};
   endfunction

endpackage

// File: rtl/lmc_debounce.sv
// rtl/lmc_debounce.sv - 2-FF synchroniser plus stable-count debouncer for a raw push button
module lmc_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw,
   output logic level,
   output logic rise
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_q1;
   logic             sync_q2;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
         cnt     <= '0;
         level   <= 1'b0;
         rise    <= 1'b0;
      end else begin
         sync_q1 <= raw;
         sync_q2 <= sync_q1;
         rise    <= 1'b0;
         // Any sample agreeing with the current level restarts the stability run.
         if (sync_q2 == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            level <= sync_q2;
            rise  <= sync_q2;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/lmc_inp_port.sv
// rtl/lmc_inp_port.sv - LMC INP peripheral: button-committed switch word over valid/ready
// Optional BCD switch preview output enabled by LMC_INP_PREVIEW_EN.
module lmc_inp_port
   import lmc_pkg::*;
#(
   parameter int DATA_W          = LMC_WORD_W,
   parameter int SW_W            = 10,
   parameter int MAX_VALUE       = LMC_MAX_VALUE,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [SW_W-1:0]   sw_value,
   input  logic              commit_btn,
   input  logic              inp_req,
   input  logic              inp_ready,
   output logic              inp_valid,
   output logic [DATA_W-1:0] inp_data,
   output logic              waiting
`ifdef LMC_INP_PREVIEW_EN
   ,
   output logic [11:0]       preview_bcd
`endif
);

   inp_state_t        state;
   logic              btn_level;
   logic              btn_rise;
   logic              press;
   logic [DATA_W-1:0] sw_clamped;

   lmc_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_commit_debounce (
      .clk    (clk),
      .reset_n(reset_n),
      .raw    (commit_btn),
      .level  (btn_level),
      .rise   (btn_rise)
   );

   assign press      = btn_rise & btn_level;
   assign sw_clamped = DATA_W'(lmc_clamp(32'(sw_value), 32'(MAX_VALUE)));

   // A press seen in IDLE or OFFER is simply dropped; only ARMED consumes it.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= IDLE;
         inp_data <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (inp_req) state <= ARMED;
            end
            ARMED: begin
               if (!inp_req) begin
                  state <= IDLE;
               end else if (press) begin
                  inp_data <= sw_clamped;
                  state    <= OFFER;
               end
            end
            OFFER: begin
               if (inp_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign inp_valid = (state == OFFER);
   assign waiting   = (state == ARMED);

`ifdef LMC_INP_PREVIEW_EN
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         preview_bcd <= 12'h000;
      end else begin
         preview_bcd <= lmc_to_bcd(10'(sw_clamped));
      end
   end
`endif

endmodule
